// File: rtl/faultify_pkg.sv
// Shared types and helpers for the fault-injection sequencer: injection modes,
// sequencer states, LFSR taps and seed conditioning.
package faultify_pkg;

   typedef enum logic [1:0] {
      INJ_OFF   = 2'd0,
      INJ_PERM  = 2'd1,
      INJ_TRANS = 2'd2,
      INJ_PROB  = 2'd3
   } injMode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } seqState_t;

   localparam logic [31:0] LFSR_TAPS = 32'h80200003;

   // An all-zero state would lock the LFSR up, so zero seeds become 1.
   function automatic logic [31:0] fixSeed(input logic [31:0] s);
      return (s == 32'h0) ? 32'h1 : s;
   endfunction

   function automatic logic [31:0] reverseBits(input logic [31:0] s);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = s[31-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/faultify_lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load and an advance enable.
module faultify_lfsr32
   import faultify_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] seed,
   input  logic        advance,
   output logic [31:0] state
);

   // Load takes priority so a new run always starts from its own seed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= 32'h1;
      end else if (load) begin
         state <= fixSeed(seed);
      end else if (advance) begin
         state <= {1'b0, state[31:1]} ^ (state[0] ? LFSR_TAPS : 32'h0);
      end
   end

endmodule

// File: rtl/faultify_injection_sequencer.sv
// Drives golden and faulty CUT copies with shared LFSR vectors, generates the
// injection vector and accumulates mismatch statistics after the CUT latency.
module faultify_injection_sequencer
   import faultify_pkg::*;
#(
   parameter int TEST_W  = 64,
   parameter int RES_W   = 23,
   parameter int INJ_W   = 13,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [31:0]       num_cycles,
   input  logic [1:0]        inj_mode,
   input  logic [INJ_W-1:0]  inj_mask,
   input  logic [31:0]       inj_cycle,
   input  logic [15:0]       prob_thresh,
   input  logic [31:0]       seed,
   output logic [TEST_W-1:0] test_vector,
   output logic [INJ_W-1:0]  injection_vector,
   input  logic [RES_W-1:0]  golden_result,
   input  logic [RES_W-1:0]  faulty_result,
   output logic              busy,
   output logic              done,
   output logic [31:0]       err_count,
   output logic              err_seen,
   output logic [31:0]       first_err_idx
);

   localparam int DRAIN_LEN = (LATENCY == 0) ? 1 : LATENCY;

   seqState_t          state, nextState;
   injMode_t           modeQ;
   logic [31:0]        numCyclesQ, injCycleQ, vecIdx;
   logic [INJ_W-1:0]   maskQ, injNext;
   logic [15:0]        threshQ;
   logic [3:0]         drainCnt;
   logic [31:0]        vecLfsr, injLfsr;
   logic [63:0]        vecDup;
   logic               startOk, running, cmpValid, mismatch;
   logic [31:0]        cmpIdx;
   logic               unusedInjBits;

   assign running       = (state == RUN);
   assign vecDup        = {vecLfsr, vecLfsr};
   assign unusedInjBits = ^injLfsr[31:16];

   faultify_lfsr32 vecLfsrInst (
      .clk     (clk),
      .rst     (rst),
      .load    (startOk),
      .seed    (seed),
      .advance (running),
      .state   (vecLfsr)
   );

   faultify_lfsr32 injLfsrInst (
      .clk     (clk),
      .rst     (rst),
      .load    (startOk),
      .seed    (reverseBits(seed)),
      .advance (running),
      .state   (injLfsr)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // A start is only honoured when idle or finished; a zero-length run skips RUN.
   always_comb begin
      nextState = state;
      startOk   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE, DONE: begin
            done = (state == DONE);
            if (start) begin
               startOk   = 1'b1;
               nextState = (num_cycles == 32'h0) ? DRAIN : RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (vecIdx == numCyclesQ - 32'd1) begin
               nextState = DRAIN;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (drainCnt == 4'(DRAIN_LEN - 1)) begin
               nextState = DONE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      injNext = '0;
      case (modeQ)
         INJ_PERM:  injNext = maskQ;
         INJ_TRANS: injNext = (vecIdx == injCycleQ) ? maskQ : '0;
         INJ_PROB:  injNext = (injLfsr[15:0] < threshQ) ? maskQ : '0;
         default:   injNext = '0;
      endcase
   end

   // The RUN-cycle valid flag and vector index are delayed to line up with results.
   generate
      if (LATENCY == 0) begin : gNoPipe
         assign cmpValid = running;
         assign cmpIdx   = vecIdx;
      end else begin : gPipe
         logic [LATENCY-1:0] validPipe;
         logic [31:0]        idxPipe [LATENCY];
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               validPipe <= '0;
               for (int i = 0; i < LATENCY; i++) begin
                  idxPipe[i] <= '0;
               end
            end else begin
               validPipe[0] <= running;
               idxPipe[0]   <= vecIdx;
               for (int i = 1; i < LATENCY; i++) begin
                  validPipe[i] <= validPipe[i-1];
                  idxPipe[i]   <= idxPipe[i-1];
               end
            end
         end
         assign cmpValid = validPipe[LATENCY-1];
         assign cmpIdx   = idxPipe[LATENCY-1];
      end
   endgenerate

   assign mismatch = cmpValid && (golden_result != faulty_result);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         modeQ            <= INJ_OFF;
         numCyclesQ       <= '0;
         injCycleQ        <= '0;
         maskQ            <= '0;
         threshQ          <= '0;
         vecIdx           <= '0;
         drainCnt         <= '0;
         test_vector      <= '0;
         injection_vector <= '0;
         err_count        <= '0;
         err_seen         <= 1'b0;
         first_err_idx    <= '0;
      end else begin
         injection_vector <= running ? injNext : '0;
         drainCnt         <= (state == DRAIN) ? drainCnt + 4'd1 : 4'd0;
         if (startOk) begin
            modeQ         <= injMode_t'(inj_mode);
            numCyclesQ    <= num_cycles;
            injCycleQ     <= inj_cycle;
            maskQ         <= inj_mask;
            threshQ       <= prob_thresh;
            vecIdx        <= '0;
            err_count     <= '0;
            err_seen      <= 1'b0;
            first_err_idx <= '0;
         end else begin
            if (running) begin
               test_vector <= vecDup[TEST_W-1:0];
               vecIdx      <= vecIdx + 32'd1;
            end
            if (mismatch) begin
               if (err_count != 32'hFFFFFFFF) begin
                  err_count <= err_count + 32'd1;
               end
               if (!err_seen) begin
                  first_err_idx <= cmpIdx;
               end
               err_seen <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_faultify_injection_sequencer.sv
// Directed bench: a one-register identity CUT on both copies, with the faulty copy
// flipping result bit 0 whenever injection bit 0 is set.
module tb_faultify_injection_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] num_cycles = '0;
   logic [1:0]  inj_mode = '0;
   logic [12:0] inj_mask = '0;
   logic [31:0] inj_cycle = '0;
   logic [15:0] prob_thresh = '0;
   logic [31:0] seed = '0;
   logic [63:0] test_vector;
   logic [12:0] injection_vector;
   logic [22:0] golden_result = '0;
   logic [22:0] faulty_result = '0;
   logic        busy, done, err_seen;
   logic [31:0] err_count, first_err_idx;

   int checksPassed = 0;
   int checksTotal  = 0;

   int          busyCycles, injNonzero;
   logic [12:0] injLastVal;
   logic [63:0] vec0, vec1;
   logic        timedOut;

   always #5 clk = ~clk;

   faultify_injection_sequencer #(
      .TEST_W(64), .RES_W(23), .INJ_W(13), .LATENCY(2)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .num_cycles       (num_cycles),
      .inj_mode         (inj_mode),
      .inj_mask         (inj_mask),
      .inj_cycle        (inj_cycle),
      .prob_thresh      (prob_thresh),
      .seed             (seed),
      .test_vector      (test_vector),
      .injection_vector (injection_vector),
      .golden_result    (golden_result),
      .faulty_result    (faulty_result),
      .busy             (busy),
      .done             (done),
      .err_count        (err_count),
      .err_seen         (err_seen),
      .first_err_idx    (first_err_idx)
   );

   // CUT model: a single register stage, so results trail the vector by one cycle.
   always_ff @(posedge clk) begin
      golden_result <= test_vector[22:0];
      faulty_result <= test_vector[22:0] ^ {22'b0, injection_vector[0]};
   end

   task automatic applyStimulus(input logic [31:0] numCyc, input logic [1:0] mode,
                                input logic [12:0] mask, input logic [31:0] injCyc,
                                input logic [15:0] thresh, input logic [31:0] seedV);
      @(negedge clk);
      num_cycles  = numCyc;
      inj_mode    = mode;
      inj_mask    = mask;
      inj_cycle   = injCyc;
      prob_thresh = thresh;
      seed        = seedV;
      start       = 1'b1;
      busyCycles  = 0;
      injNonzero  = 0;
      injLastVal  = '0;
      vec0        = '0;
      vec1        = '0;
      timedOut    = 1'b1;
      for (int c = 0; c < 25000; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) begin
            if (busyCycles == 1) vec0 = test_vector;
            if (busyCycles == 2) vec1 = test_vector;
            busyCycles++;
         end
         if (injection_vector != '0) begin
            injNonzero++;
            injLastVal = injection_vector;
         end
         if (done) begin
            timedOut = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int injSeen = 0;
      int busySeen = 0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checksTotal++;
      if ({busy, done, err_seen} !== 3'b000) $display("[TB] FAIL reset_flags: got %b, expected 000", {busy, done, err_seen});
      else checksPassed++;
      checksTotal++;
      if (test_vector !== 64'h0) $display("[TB] FAIL reset_test_vector: got %0h, expected 0", test_vector);
      else checksPassed++;
      checksTotal++;
      if ({err_count, first_err_idx} !== 64'h0) $display("[TB] FAIL reset_stats: got %0h/%0h, expected 0/0", err_count, first_err_idx);
      else checksPassed++;
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (injection_vector != '0) injSeen++;
         if (busy) busySeen++;
      end
      checksTotal++;
      if (injSeen !== 0) $display("[TB] FAIL idle_injection: got %0d nonzero cycles, expected 0", injSeen);
      else checksPassed++;
      checksTotal++;
      if (busySeen !== 0) $display("[TB] FAIL idle_busy: got %0d busy cycles, expected 0", busySeen);
      else checksPassed++;
   endtask

   task automatic test_mode_off();
      applyStimulus(32'd100, 2'd0, 13'h1FFF, 32'd0, 16'h0, 32'h0);
      checksTotal++;
      if (timedOut !== 1'b0) $display("[TB] FAIL off_timeout: got %b, expected 0", timedOut);
      else checksPassed++;
      checksTotal++;
      if (busyCycles !== 102) $display("[TB] FAIL off_busy_cycles: got %0d, expected 102", busyCycles);
      else checksPassed++;
      checksTotal++;
      if ({done, err_seen, err_count} !== {1'b1, 1'b0, 32'd0}) $display("[TB] FAIL off_stats: got done=%b seen=%b cnt=%0d, expected 1/0/0", done, err_seen, err_count);
      else checksPassed++;
      checksTotal++;
      if (vec0 !== 64'h00000001_00000001) $display("[TB] FAIL off_vector0: got %h, expected 0000000100000001", vec0);
      else checksPassed++;
      checksTotal++;
      if (vec1 !== 64'h80200003_80200003) $display("[TB] FAIL off_vector1: got %h, expected 8020000380200003", vec1);
      else checksPassed++;
      checksTotal++;
      if (injNonzero !== 0) $display("[TB] FAIL off_injection: got %0d nonzero cycles, expected 0", injNonzero);
      else checksPassed++;
   endtask

   task automatic test_transient();
      applyStimulus(32'd20, 2'd2, 13'h0001, 32'd5, 16'h0, 32'h1234);
      checksTotal++;
      if (timedOut !== 1'b0) $display("[TB] FAIL trans_timeout: got %b, expected 0", timedOut);
      else checksPassed++;
      checksTotal++;
      if (injNonzero !== 1 || injLastVal !== 13'h0001) $display("[TB] FAIL trans_injection: got %0d cycles value %0h, expected 1 cycle value 1", injNonzero, injLastVal);
      else checksPassed++;
      checksTotal++;
      if (err_count !== 32'd1) $display("[TB] FAIL trans_err_count: got %0d, expected 1", err_count);
      else checksPassed++;
      checksTotal++;
      if ({err_seen, first_err_idx} !== {1'b1, 32'd5}) $display("[TB] FAIL trans_first_idx: got seen=%b idx=%0d, expected 1/5", err_seen, first_err_idx);
      else checksPassed++;
   endtask

   task automatic test_permanent_then_clear();
      applyStimulus(32'd10, 2'd1, 13'h1FFF, 32'd0, 16'h0, 32'h55);
      checksTotal++;
      if (injNonzero !== 10 || injLastVal !== 13'h1FFF) $display("[TB] FAIL perm_injection: got %0d cycles value %0h, expected 10 cycles value 1fff", injNonzero, injLastVal);
      else checksPassed++;
      checksTotal++;
      if (err_count !== 32'd10) $display("[TB] FAIL perm_err_count: got %0d, expected 10", err_count);
      else checksPassed++;
      checksTotal++;
      if ({err_seen, first_err_idx} !== {1'b1, 32'd0}) $display("[TB] FAIL perm_first_idx: got seen=%b idx=%0d, expected 1/0", err_seen, first_err_idx);
      else checksPassed++;
      applyStimulus(32'd10, 2'd0, 13'h1FFF, 32'd0, 16'h0, 32'h55);
      checksTotal++;
      if ({timedOut, err_seen, err_count} !== {1'b0, 1'b0, 32'd0}) $display("[TB] FAIL clear_stats: got to=%b seen=%b cnt=%0d, expected 0/0/0", timedOut, err_seen, err_count);
      else checksPassed++;
   endtask

   task automatic test_probabilistic();
      logic [31:0] firstCount;
      applyStimulus(32'd1000, 2'd3, 13'h0001, 32'd0, 16'h0000, 32'hACE1);
      checksTotal++;
      if (err_count !== 32'd0 || injNonzero !== 0) $display("[TB] FAIL prob_zero: got cnt=%0d inj=%0d, expected 0/0", err_count, injNonzero);
      else checksPassed++;
      applyStimulus(32'd10000, 2'd3, 13'h0001, 32'd0, 16'h8000, 32'hACE1);
      firstCount = err_count;
      checksTotal++;
      if (timedOut !== 1'b0 || err_count < 32'd4800 || err_count > 32'd5200) $display("[TB] FAIL prob_half: got cnt=%0d to=%b, expected 4800..5200", err_count, timedOut);
      else checksPassed++;
      checksTotal++;
      if (injNonzero !== int'(firstCount)) $display("[TB] FAIL prob_inj_vs_err: got %0d injections, expected %0d", injNonzero, firstCount);
      else checksPassed++;
      applyStimulus(32'd10000, 2'd3, 13'h0001, 32'd0, 16'h8000, 32'hACE1);
      checksTotal++;
      if (err_count !== firstCount) $display("[TB] FAIL prob_replay: got %0d, expected %0d", err_count, firstCount);
      else checksPassed++;
   endtask

   task automatic test_reset_mid_run();
      int seen = 0;
      @(negedge clk);
      num_cycles = 32'd100;
      inj_mode   = 2'd1;
      inj_mask   = 13'h1FFF;
      seed       = 32'h77;
      start      = 1'b1;
      for (int c = 0; c < 200 && seen < 51; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) seen++;
      end
      checksTotal++;
      if (err_count === 32'd0) $display("[TB] FAIL midrun_pre_errors: got %0d, expected nonzero", err_count);
      else checksPassed++;
      rst = 1'b0;
      #1;
      checksTotal++;
      if ({busy, done, err_seen, injection_vector} !== 16'h0) $display("[TB] FAIL midrun_flags: got busy=%b done=%b seen=%b inj=%0h, expected all 0", busy, done, err_seen, injection_vector);
      else checksPassed++;
      checksTotal++;
      if ({test_vector, err_count, first_err_idx} !== 128'h0) $display("[TB] FAIL midrun_data: got tv=%0h cnt=%0d idx=%0d, expected 0", test_vector, err_count, first_err_idx);
      else checksPassed++;
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(32'd0, 2'd0, 13'h0, 32'd0, 16'h0, 32'h0);
      checksTotal++;
      if ({timedOut, done} !== 2'b01 || busyCycles !== 2) $display("[TB] FAIL zero_run: got to=%b done=%b busy=%0d, expected 0/1/2", timedOut, done, busyCycles);
      else checksPassed++;
      checksTotal++;
      if (err_count !== 32'd0) $display("[TB] FAIL zero_run_errors: got %0d, expected 0", err_count);
      else checksPassed++;
   endtask

   initial begin
      $display("[TB] starting faultify_injection_sequencer bench");
      test_reset();
      test_mode_off();
      test_transient();
      test_permanent_then_clear();
      test_probabilistic();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
